// File: rtl/buf_readout.sv
// buf_readout: arms on a listen rise, counts DEPTH strobe rises into the ring
// buffer, then reads the frame back one word at a time over a valid/ready
// handshake. A wrapping checksum of the accepted words is published at the end.
module buf_readout #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             listen,
    input  logic             strobe,
    input  logic [WIDTH-1:0] dout,
    output logic [PW-1:0]    readPtr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [WIDTH-1:0] csum,
    output logic             csum_valid,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [PW:0]   WCNT_LAST = (PW + 1)'(DEPTH - 1);
    localparam logic [PW-1:0] RPTR_LAST = PW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [PW:0]      wcnt_q, wcnt_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic             csum_valid_q, csum_valid_d;
    logic             overrun_q, overrun_d;
    logic             listen_q, strobe_q;
    // Blocks a listen level that was already high across reset from looking
    // like a fresh arm request; it only opens once listen has been seen low.
    logic             listen_low_q, listen_low_d;
    logic             listen_rise, strobe_rise;

    // Edge detection on the registered copies; suppressed while reset is asserted.
    always_comb begin
        listen_rise  = reset && listen && !listen_q && listen_low_q;
        strobe_rise  = reset && strobe && !strobe_q;
        listen_low_d = listen_low_q || !listen;
    end

    // Next-state, counters, readout datapath and checksum accumulation.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rptr_d       = rptr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        acc_d        = acc_q;
        csum_d       = csum_q;
        csum_valid_d = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (listen_rise) begin
                    state_d   = FILL;
                    wcnt_d    = '0;
                    acc_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            FILL: begin
                // A restart wins over a strobe rise on the same cycle.
                if (listen_rise) begin
                    wcnt_d = '0;
                    acc_d  = '0;
                end else if (strobe_rise) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = READ;
                        rptr_d  = '0;
                    end
                end
            end
            READ: begin
                // dout reflects readPtr by the end of this single cycle.
                out_data_d  = dout;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = acc_q + out_data_q;
                    if (rptr_q == RPTR_LAST) begin
                        state_d = DONE;
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                csum_d       = acc_q;
                csum_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Writes while the frame is being read out are flagged, not acted on.
        if (strobe_rise && (state_q == READ || state_q == SEND || state_q == DONE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            rptr_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
            csum_q       <= '0;
            csum_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            listen_q     <= 1'b0;
            strobe_q     <= 1'b0;
            listen_low_q <= !listen;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rptr_q       <= rptr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            acc_q        <= acc_d;
            csum_q       <= csum_d;
            csum_valid_q <= csum_valid_d;
            overrun_q    <= overrun_d;
            listen_q     <= listen;
            strobe_q     <= strobe;
            listen_low_q <= listen_low_d;
        end
    end

    // Output drive.
    always_comb begin
        readPtr    = rptr_q;
        out_data   = out_data_q;
        out_valid  = out_valid_q;
        out_last   = out_valid_q && (rptr_q == RPTR_LAST);
        csum       = csum_q;
        csum_valid = csum_valid_q;
        busy       = (state_q != IDLE);
        overrun    = overrun_q;
    end

endmodule
